// File: rtl/mod_pkg.sv
// Shared types and constants for the repeated-subtraction modulo unit.
package mod_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mod_ctrl.sv
// Sequencer for mod_dp: computes a mod b and floor(a/b) by repeated subtraction,
// with divide-by-zero and iteration-limit aborts.
module mod_ctrl
  import mod_pkg::*;
#(
  parameter int MAX_ITER = 1024,
  parameter int W        = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] remainder,
  output logic [W-1:0] quotient,
  output logic         err_div0,
  output logic         err_timeout,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic         dp_load_a,
  output logic         dp_subtract,
  input  logic [W-1:0] dp_temp,
  input  logic         dp_lt
);

  localparam logic [W-1:0] MAX_Q = W'(MAX_ITER);

  state_t       state, state_nxt;
  logic [W-1:0] a_q, b_q;
  logic         at_limit;

  // quotient doubles as the iteration counter; it can never exceed MAX_Q
  assign at_limit = (quotient == MAX_Q);

  assign dp_a = a_q;
  assign dp_b = b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    dp_load_a   = 1'b0;
    dp_subtract = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (op_b != '0) ? LOAD : DONE;
      end
      LOAD: begin
        dp_load_a = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (dp_lt || at_limit) state_nxt = DONE;
        else                   dp_subtract = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latches and result registers; a_q/b_q only move on an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      busy        <= 1'b0;
      remainder   <= '0;
      quotient    <= '0;
      err_div0    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q         <= op_a;
            b_q         <= op_b;
            quotient    <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            err_div0    <= (op_b == '0);
            if (op_b == '0) remainder <= '0;
          end
        end
        RUN: begin
          if (dp_lt) begin
            remainder <= dp_temp;
          end else if (at_limit) begin
            err_timeout <= 1'b1;
            remainder   <= dp_temp;
          end else begin
            quotient <= quotient + 1'b1;
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_ctrl.sv
// Directed bench for mod_ctrl with a small behavioural mod_dp alongside each instance.
module tb_mod_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;

  logic        busy0, done0, div00, to0, ld0, sb0, lt0;
  logic [31:0] rem0, quo0, dpa0, dpb0, temp0;
  logic        busy1, done1, div01, to1, ld1, sb1, lt1;
  logic [31:0] rem1, quo1, dpa1, dpb1, temp1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mod_ctrl #(.MAX_ITER(1024), .W(32)) u0 (
    .clk(clk), .reset(reset), .start(start0), .op_a(op_a), .op_b(op_b),
    .busy(busy0), .done(done0), .remainder(rem0), .quotient(quo0),
    .err_div0(div00), .err_timeout(to0), .dp_a(dpa0), .dp_b(dpb0),
    .dp_load_a(ld0), .dp_subtract(sb0), .dp_temp(temp0), .dp_lt(lt0)
  );

  mod_ctrl #(.MAX_ITER(4), .W(32)) u1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(op_a), .op_b(op_b),
    .busy(busy1), .done(done1), .remainder(rem1), .quotient(quo1),
    .err_div0(div01), .err_timeout(to1), .dp_a(dpa1), .dp_b(dpb1),
    .dp_load_a(ld1), .dp_subtract(sb1), .dp_temp(temp1), .dp_lt(lt1)
  );

  // Reference datapath: temp loads a, subtracts b, flags temp < b
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    temp0 <= '0;
    else if (ld0) temp0 <= dpa0;
    else if (sb0) temp0 <= temp0 - dpb0;
  end
  assign lt0 = (temp0 < dpb0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    temp1 <= '0;
    else if (ld1) temp1 <= dpa1;
    else if (sb1) temp1 <= temp1 - dpb1;
  end
  assign lt1 = (temp1 < dpb1);

  // Issues one start and waits for done; lat = k where done is seen in the cycle after E0+k
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int loads, output int subs,
                        output bit busy_ok, output bit both_hi);
    @(negedge clk);
    op_a = a;
    op_b = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    op_a = 32'hdead_beef;
    op_b = 32'h0000_0003;
    lat = -1; loads = 0; subs = 0; busy_ok = 1'b1; both_hi = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!(sel ? busy1 : busy0)) busy_ok = 1'b0;
      if (sel ? ld1 : ld0) loads++;
      if (sel ? sb1 : sb0) subs++;
      if ((sel ? ld1 : ld0) && (sel ? sb1 : sb0)) both_hi = 1'b1;
      if (sel ? done1 : done0) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    checks++;
    if ({busy0, done0, div00, to0, ld0, sb0} !== 6'b0)
      $display("FAIL reset_ctrl: got %b, want 000000", {busy0, done0, div00, to0, ld0, sb0});
    else passed++;
    checks++;
    if ({rem0, quo0, dpa0, dpb0} !== 128'b0)
      $display("FAIL reset_data: rem=%0d quo=%0d dp_a=%0d dp_b=%0d, want all 0", rem0, quo0, dpa0, dpb0);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat, loads, subs; bit bok, both;
    run_op(1'b0, 32'd17, 32'd5, lat, loads, subs, bok, both);
    checks++; if (lat !== 5) $display("FAIL basic_latency: got %0d, want 5", lat); else passed++;
    checks++; if (rem0 !== 32'd2) $display("FAIL basic_rem: got %0d, want 2", rem0); else passed++;
    checks++; if (quo0 !== 32'd3) $display("FAIL basic_quo: got %0d, want 3", quo0); else passed++;
    checks++; if ({div00, to0} !== 2'b00) $display("FAIL basic_err: got %b, want 00", {div00, to0}); else passed++;
    checks++; if (!bok || both) $display("FAIL basic_busy_excl: busy_ok=%0d both=%0d, want 1 0", bok, both); else passed++;
    checks++; if (dpa0 !== 32'd17 || dpb0 !== 32'd5)
      $display("FAIL basic_dp_ab: got %0d %0d, want 17 5", dpa0, dpb0); else passed++;
    checks++; if (loads !== 1 || subs !== 3) $display("FAIL basic_pulses: got %0d %0d, want 1 3", loads, subs); else passed++;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0)
      $display("FAIL basic_idle: busy=%b done=%b, want 0 0", busy0, done0); else passed++;
  endtask

  task automatic test_div0;
    int lat, loads, subs; bit bok, both;
    run_op(1'b0, 32'd9, 32'd0, lat, loads, subs, bok, both);
    checks++; if (lat !== 0) $display("FAIL div0_latency: got %0d, want 0", lat); else passed++;
    checks++; if (div00 !== 1'b1 || to0 !== 1'b0)
      $display("FAIL div0_flags: got %b%b, want 10", div00, to0); else passed++;
    checks++; if (rem0 !== 32'd0 || quo0 !== 32'd0)
      $display("FAIL div0_results: got %0d %0d, want 0 0", rem0, quo0); else passed++;
    checks++; if (loads !== 0 || subs !== 0) $display("FAIL div0_dp_idle: got %0d %0d, want 0 0", loads, subs); else passed++;
    @(negedge clk);
  endtask

  task automatic test_small;
    int lat, loads, subs; bit bok, both;
    run_op(1'b0, 32'd3, 32'd5, lat, loads, subs, bok, both);
    checks++; if (lat !== 2) $display("FAIL small_latency: got %0d, want 2", lat); else passed++;
    checks++; if (rem0 !== 32'd3 || quo0 !== 32'd0 || div00 !== 1'b0)
      $display("FAIL small_results: got %0d %0d %b, want 3 0 0", rem0, quo0, div00); else passed++;
    checks++; if (subs !== 0) $display("FAIL small_subs: got %0d, want 0", subs); else passed++;
    @(negedge clk);
  endtask

  task automatic test_exact;
    int lat, loads, subs; bit bok, both;
    run_op(1'b0, 32'd20, 32'd5, lat, loads, subs, bok, both);
    checks++; if (lat !== 6) $display("FAIL exact_latency: got %0d, want 6", lat); else passed++;
    checks++; if (rem0 !== 32'd0 || quo0 !== 32'd4)
      $display("FAIL exact_results: got %0d %0d, want 0 4", rem0, quo0); else passed++;
    @(negedge clk);
    run_op(1'b0, 32'd0, 32'd7, lat, loads, subs, bok, both);
    checks++; if (lat !== 2 || rem0 !== 32'd0 || quo0 !== 32'd0)
      $display("FAIL zero_dividend: lat=%0d rem=%0d quo=%0d, want 2 0 0", lat, rem0, quo0); else passed++;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat, loads, subs; bit bok, both;
    run_op(1'b1, 32'd100, 32'd1, lat, loads, subs, bok, both);
    checks++; if (to1 !== 1'b1 || div01 !== 1'b0)
      $display("FAIL timeout_flags: got to=%b div0=%b, want 1 0", to1, div01); else passed++;
    checks++; if (quo1 !== 32'd4 || rem1 !== 32'd96)
      $display("FAIL timeout_results: got %0d %0d, want 4 96", quo1, rem1); else passed++;
    checks++; if (lat !== 6) $display("FAIL timeout_latency: got %0d, want 6", lat); else passed++;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(negedge clk);
    op_a = 32'd17; op_b = 32'd5; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; op_a = 32'd100; op_b = 32'd3;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start0 = (k == 2);
      if (done0) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat !== 5 || rem0 !== 32'd2 || quo0 !== 32'd3)
      $display("FAIL busy_ignore: lat=%0d rem=%0d quo=%0d, want 5 2 3", lat, rem0, quo0); else passed++;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || ld0 !== 1'b0)
      $display("FAIL done_start_ignored: busy=%b load=%b, want 0 0", busy0, ld0); else passed++;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || dpa0 !== 32'd17)
      $display("FAIL done_start_latch: busy=%b dp_a=%0d, want 0 17", busy0, dpa0); else passed++;
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    @(negedge clk);
    op_a = 32'd1000; op_b = 32'd1; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (sb0 !== 1'b1 || busy0 !== 1'b1)
      $display("FAIL mid_run_active: sub=%b busy=%b, want 1 1", sb0, busy0); else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({busy0, done0, div00, to0, ld0, sb0} !== 6'b0 || {rem0, quo0, dpa0, dpb0} !== 128'b0)
      $display("FAIL mid_reset_clear: busy=%b quo=%0d dp_a=%0d dp_b=%0d, want all 0", busy0, quo0, dpa0, dpb0);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done0 || busy0) saw_done = 1'b1;
    end
    checks++; if (saw_done) $display("FAIL mid_reset_no_done: got done/busy activity, want none"); else passed++;
  endtask

  task automatic test_after_reset;
    int lat, loads, subs; bit bok, both;
    run_op(1'b0, 32'd17, 32'd5, lat, loads, subs, bok, both);
    checks++; if (lat !== 5 || rem0 !== 32'd2 || quo0 !== 32'd3 || div00 !== 1'b0 || to0 !== 1'b0)
      $display("FAIL after_reset: lat=%0d rem=%0d quo=%0d, want 5 2 3", lat, rem0, quo0); else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_small();
    test_exact();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    test_after_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
